// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, write-type encodings and state type for the data-memory arbiter.
package dmem_arbiter_pkg;
  localparam int MEMORY_ADDR_W      = 32;
  localparam int MEMORY_DATA_W      = 32;
  localparam int MEMORY_WRITE_TYP_W = 2;
  localparam int DMEM_ARB_NREQ      = 2;

  localparam logic [MEMORY_WRITE_TYP_W-1:0] WTYP_BU   = 2'd0;
  localparam logic [MEMORY_WRITE_TYP_W-1:0] WTYP_HU   = 2'd1;
  localparam logic [MEMORY_WRITE_TYP_W-1:0] WTYP_WORD = 2'd2;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time gets the grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (&valid) grant = last_grant ? 2'b01 : 2'b10;
    else        grant = valid;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the core LSU (port 0) and debug/loader (port 1),
// with one registered response slot that can drain and refill in the same cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEMORY_ADDR_W,
  parameter int DATA_W = MEMORY_DATA_W,
  parameter int TYP_W  = MEMORY_WRITE_TYP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DMEM_ARB_NREQ-1:0]   req_valid,
  output logic [DMEM_ARB_NREQ-1:0]   req_ready,
  input  logic [DMEM_ARB_NREQ-1:0]   req_we,
  input  logic [2*ADDR_W-1:0]        req_addr,
  input  logic [2*DATA_W-1:0]        req_wdata,
  input  logic [2*TYP_W-1:0]         req_wtyp,
  output logic [DMEM_ARB_NREQ-1:0]   rsp_valid,
  input  logic [DMEM_ARB_NREQ-1:0]   rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wenable,
  output logic [TYP_W-1:0]           mem_wtyp,
  input  logic [DATA_W-1:0]          mem_rdata
);
  arb_state_e state;
  logic       rsp_port;
  logic       last_grant;
  logic [1:0] grant;
  logic [1:0] accept;
  logic       can_issue;
  logic       any_acc;
  logic       sel;

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // The slot may be refilled in the same cycle its owner consumes it.
  assign can_issue = (state == ARB_IDLE) | rsp_ready[rsp_port];
  assign req_ready = can_issue ? grant : 2'b00;
  assign accept    = req_valid & req_ready;
  assign any_acc   = |accept;
  assign sel       = any_acc & accept[1];

  // With no accept the mux rests on port 0 so the address stays stable.
  assign mem_addr    = sel ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
  assign mem_wdata   = sel ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
  assign mem_wtyp    = sel ? req_wtyp[TYP_W +: TYP_W]     : req_wtyp[0 +: TYP_W];
  assign mem_wenable = any_acc & req_we[sel] & ~rst;

  // last_grant resets to 1 so port 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_port   <= 1'b0;
      last_grant <= 1'b1;
    end else if (any_acc) begin
      state      <= ARB_HOLD;
      rsp_valid  <= onehot2(sel);
      rsp_rdata  <= req_we[sel] ? '0 : mem_rdata;
      rsp_port   <= sel;
      last_grant <= sel;
    end else if (state == ARB_HOLD && rsp_ready[rsp_port]) begin
      state     <= ARB_IDLE;
      rsp_valid <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian dmem stand-in.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_wtyp;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wenable;
  logic [1:0]  mem_wtyp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wtyp(req_wtyp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .mem_wtyp(mem_wtyp), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = mem_addr[9:0];
  assign mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_wenable) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_wtyp != WTYP_BU) mem[ma + 10'd1] <= mem_wdata[15:8];
      if (mem_wtyp == WTYP_WORD) begin
        mem[ma + 10'd2] <= mem_wdata[23:16];
        mem[ma + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] memword(input logic [9:0] a);
    return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] t);
    req_we[p]            = we;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = d;
    req_wtyp[p*2 +: 2]   = t;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t);
    set_port(p, 1'b1, a, d, t);
    rsp_ready = 2'b11;
    req_valid = (p == 1) ? 2'b10 : 2'b01;
    step();
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_reset;
    set_port(0, 1'b1, 32'h40, 32'h5555AAAA, WTYP_WORD);
    set_port(1, 1'b1, 32'h40, 32'h5555AAAA, WTYP_WORD);
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    n_vec++; if (mem_wenable !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", mem_wenable); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    step();
    step();
    n_vec++; if (memword(10'h40) !== 32'h01020304) begin n_err++; $display("FAIL reset_mem: got %h want 01020304", memword(10'h40)); end
    req_valid = 2'b00;
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read;
    rsp_ready = 2'b01;
    set_port(0, 1'b1, 32'h100, 32'hDEADBEEF, WTYP_WORD);
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    n_vec++; if (mem_wenable !== 1'b1) begin n_err++; $display("FAIL wr_wen: got %b want 1", mem_wenable); end
    n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL wr_addr: got %h want 100", mem_addr); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL wr_ack: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_ack_data: got %h want 0", rsp_rdata); end
    set_port(0, 1'b0, 32'h100, 32'h0, WTYP_WORD);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rd_ready: got %b want 01", req_ready); end
    n_vec++; if (mem_wenable !== 1'b0) begin n_err++; $display("FAIL rd_wen: got %b want 0", mem_wenable); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
    req_valid = 2'b00;
    step();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_drain: got %b want 00", rsp_valid); end
  endtask

  task automatic test_fairness;
    logic [1:0] prev;
    logic [1:0] exp;
    do_reset();
    set_port(0, 1'b0, 32'h100, 32'h0, WTYP_WORD);
    set_port(1, 1'b0, 32'h40, 32'h0, WTYP_WORD);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++; if (req_ready !== exp) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp); end
      n_vec++; if (rsp_valid !== prev) begin n_err++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, rsp_valid, prev); end
      prev = exp;
      step();
    end
    n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL rr_last_rsp: got %b want 10", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h01020304) begin n_err++; $display("FAIL rr_last_data: got %h want 01020304", rsp_rdata); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure;
    do_reset();
    do_write(1, 32'h300, 32'hCAFEF00D, WTYP_WORD);
    rsp_ready = 2'b00;
    set_port(1, 1'b0, 32'h300, 32'h0, WTYP_WORD);
    req_valid = 2'b10;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_accept: got %b want 10", req_ready); end
    step();
    set_port(0, 1'b0, 32'h100, 32'h0, WTYP_WORD);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 10", i, rsp_valid); end
      n_vec++; if (rsp_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL bp_data[%0d]: got %h want cafef00d", i, rsp_rdata); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready); end
      step();
    end
    rsp_ready = 2'b10;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_drain_ready: got %b want 01", req_ready); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_refill_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL bp_refill_data: got %h want deadbeef", rsp_rdata); end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
  endtask

  task automatic test_byte_write;
    do_write(0, 32'h100, 32'h11223344, WTYP_WORD);
    do_write(0, 32'h103, 32'h000000AB, WTYP_BU);
    rsp_ready = 2'b01;
    set_port(0, 1'b0, 32'h100, 32'h0, WTYP_WORD);
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bu_ready: got %b want 01", req_ready); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bu_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'hAB223344) begin n_err++; $display("FAIL bu_data: got %h want ab223344", rsp_rdata); end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_async_reset;
    do_reset();
    rsp_ready = 2'b00;
    set_port(1, 1'b0, 32'h300, 32'h0, WTYP_WORD);
    req_valid = 2'b10;
    step();
    n_vec++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL ar_hold: got %b want 10", rsp_valid); end
    req_valid = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL ar_drop: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL ar_rdata: got %h want 0", rsp_rdata); end
    #2;
    rst = 1'b0;
    set_port(0, 1'b0, 32'h100, 32'h0, WTYP_WORD);
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL ar_first_grant: got %b want 01", req_ready); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL ar_first_rsp: got %b want 01", rsp_valid); end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_wtyp  = '0;
    rsp_ready = 2'b00;
    do_reset();
    do_write(0, 32'h40, 32'h01020304, WTYP_WORD);
    test_reset();
    test_write_read();
    test_fairness();
    test_backpressure();
    test_byte_write();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
